prescaler_sched: RTL and testbench
==================================

Name: prescaler_sched

Overview:
Multi-channel programmable prescaler scheduler. It replaces fixed power-of-two prescalers with NCH independent channels, each with a runtime-loadable divisor and a periodic or one-shot mode. Each channel produces a one-cycle tick enable and a divided square wave, all synchronous to the single system clock. It sits between the top level and the timing consumers (blink, scroll and refresh logic) and is configured through a single-cycle write port.

Parameters:
NCH, 4, number of channels
W, 22, divisor and counter width in bits
CW, 2, channel-select width; must satisfy 2**CW >= NCH

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  config write strobe, single cycle
cfg_ch  input  CW  channel addressed by the write
cfg_div  input  W  divisor; 0 stops the channel
cfg_oneshot  input  1  1 = one-shot mode, 0 = periodic mode
hold  input  1  global pause; freezes all channel counters
tick  output  NCH  per-channel one-cycle enable pulse
clk_out  output  NCH  per-channel square wave; toggles on each tick
busy  output  NCH  channel is in RUN
done  output  NCH  one-shot channel has fired

Behaviour:
- Interface: one clock, clk_in. Reset rst_n is asynchronous and active-low.
- Reset: all channels go to IDLE. tick, clk_out, busy and done are 0. Counters and divisor registers are 0.
- Per-channel state: div[W-1:0], cnt[W-1:0], mode, and FSM state in {IDLE, RUN, DONE}. busy = (state==RUN). done = (state==DONE).
- Config write (cfg_we=1, cfg_ch<NCH):
  - The addressed channel latches div and mode, and clears cnt, tick and clk_out.
  - If cfg_div != 0, the next state is RUN; if cfg_div == 0, the next state is IDLE.
  - A write with cfg_ch >= NCH is ignored.
  - Only the addressed channel is affected.
- RUN, hold=0:
  - If cnt == div-1: cnt <= 0, tick <= 1, clk_out <= ~clk_out. If mode is one-shot, state <= DONE.
  - Otherwise: cnt <= cnt+1, tick <= 0.
- RUN, hold=1: cnt and clk_out hold their values; tick <= 0. No tick is lost, only delayed.
- IDLE and DONE: tick = 0, clk_out holds its value, cnt holds its value. Only a config write leaves these states.
- Timing:
  - tick and clk_out are registered.
  - A write on edge k with divisor D produces the first tick high during the cycle after edge k+D.
  - Periodic mode then ticks every D cycles, giving a clk_out period of 2D cycles.
- Divisor D=1: tick is high every cycle while running, and clk_out toggles every cycle.
- Maximum divisor: D = 2**W-1 is legal. cnt never exceeds div-1, so no wrap beyond that is possible.
- Write in the same cycle as a terminal count on the same channel: the write wins. No tick is issued, and clk_out and cnt clear.
- Write while hold=1: the write still takes effect, and the channel stays frozen at cnt=0 until hold drops.
- Reset asserted mid-count: all outputs clear asynchronously and immediately. After rst_n rises, every channel is IDLE until written again.
- Channels are fully independent. Simultaneous ticks on several channels are legal.

Test Plan:
- Reset then idle: assert rst_n=0 mid-run -> tick, clk_out, busy and done are 0 immediately; all stay 0 for 20 cycles after release with no writes.
- Periodic, ch0, D=5: write on edge k -> tick high in the cycles after edges k+5, k+10, k+15; clk_out period 10; busy=1 throughout.
- One-shot, ch2, D=3: write -> exactly one tick, after edge k+3; then busy=0, done=1, and no further ticks for 50 cycles. Rewriting ch2 with D=0 -> done=0 and state IDLE.
- D=1 and hold, ch1: tick=1 every cycle and clk_out toggles. Assert hold for 4 cycles -> tick=0 and clk_out frozen; after release, ticking resumes next cycle.
- Collision, ch3, D=4: rewrite ch3 with D=2 on the same edge where a tick would issue -> no tick that cycle; next tick arrives 2 cycles later. Channels 0-2 are unaffected.
- Boundaries: write cfg_ch=NCH (with CW large enough to address it) -> no channel changes. Run W=4 with D=15 -> ticks every 15 cycles and cnt never exceeds 14.

Source files
------------

// File: rtl/prescaler_sched.sv
// Multi-channel programmable prescaler: per-channel tick pulse and divided square wave.
// Latency: a write on edge k with divisor D gives the first tick in the cycle after edge k+D.
// Backpressure: none; hold freezes every running channel without losing a pending tick.
module prescaler_sched #(
    parameter int NCH = 4,
    parameter int W   = 22,
    parameter int CW  = 2
) (
    input  logic           clk_in,
    input  logic           rst_n,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [W-1:0]   cfg_div,
    input  logic           cfg_oneshot,
    input  logic           hold,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [W-1:0] div;
        logic [W-1:0] cnt;
        logic         oneshot;
        logic         tick;
        logic         clk_out;
        state_t       state;
    } chan_t;

    chan_t ch_q [NCH];
    chan_t ch_d [NCH];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                ch_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                ch_q[c] <= ch_d[c];
            end
        end
    end

    // A write to a channel overrides whatever its counter would have done this cycle.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            ch_d[c]      = ch_q[c];
            ch_d[c].tick = 1'b0;
            if (cfg_we && (cfg_ch == CW'(c))) begin
                ch_d[c].div     = cfg_div;
                ch_d[c].oneshot = cfg_oneshot;
                ch_d[c].cnt     = '0;
                ch_d[c].clk_out = 1'b0;
                ch_d[c].state   = (cfg_div != '0) ? RUN : IDLE;
            end else if ((ch_q[c].state == RUN) && !hold) begin
                if (ch_q[c].cnt == ch_q[c].div - W'(1)) begin
                    ch_d[c].cnt     = '0;
                    ch_d[c].tick    = 1'b1;
                    ch_d[c].clk_out = ~ch_q[c].clk_out;
                    if (ch_q[c].oneshot) begin
                        ch_d[c].state = DONE;
                    end
                end else begin
                    ch_d[c].cnt = ch_q[c].cnt + W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign tick[g]    = ch_q[g].tick;
        assign clk_out[g] = ch_q[g].clk_out;
        assign busy[g]    = (ch_q[g].state == RUN);
        assign done[g]    = (ch_q[g].state == DONE);
    end

endmodule

// File: tb/tb_prescaler_sched.sv
// Bench for prescaler_sched: directed scenarios plus random traffic against a countdown model.
module tb_prescaler_sched;

    localparam int NCH = 4;
    localparam int W   = 22;
    localparam int CW  = 3;
    localparam int SW  = 4;
    localparam int SCW = 2;

    logic           clk_in = 1'b0;
    logic           rst_n;
    logic           cfg_we;
    logic [CW-1:0]  cfg_ch;
    logic [W-1:0]   cfg_div;
    logic           cfg_oneshot;
    logic           hold;
    logic [NCH-1:0] tick, clk_out, busy, done;

    logic           s_we;
    logic [SCW-1:0] s_ch;
    logic [SW-1:0]  s_div;
    logic           s_oneshot;
    logic           s_hold;
    logic [NCH-1:0] s_tick, s_clk_out, s_busy, s_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each running channel counts down the cycles left until its next tick.
    int             m_st  [NCH];   // 0 idle, 1 running, 2 fired
    int             m_rem [NCH];
    int             m_div [NCH];
    bit             m_one [NCH];
    logic [NCH-1:0] m_tick, m_clk;

    always #5 clk_in = ~clk_in;

    prescaler_sched #(.NCH(NCH), .W(W), .CW(CW)) u_dut (
        .clk_in(clk_in), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .hold(hold),
        .tick(tick), .clk_out(clk_out), .busy(busy), .done(done)
    );

    prescaler_sched #(.NCH(NCH), .W(SW), .CW(SCW)) u_small (
        .clk_in(clk_in), .rst_n(rst_n), .cfg_we(s_we), .cfg_ch(s_ch),
        .cfg_div(s_div), .cfg_oneshot(s_oneshot), .hold(s_hold),
        .tick(s_tick), .clk_out(s_clk_out), .busy(s_busy), .done(s_done)
    );

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_st[c] = 0; m_rem[c] = 0; m_div[c] = 0; m_one[c] = 1'b0;
        end
        m_tick = '0;
        m_clk  = '0;
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            m_tick[c] = 1'b0;
            if (cfg_we && (int'(cfg_ch) == c)) begin
                m_div[c] = int'(cfg_div);
                m_rem[c] = int'(cfg_div);
                m_one[c] = cfg_oneshot;
                m_clk[c] = 1'b0;
                m_st[c]  = (cfg_div != 0) ? 1 : 0;
            end else if (m_st[c] == 1 && !hold) begin
                m_rem[c] = m_rem[c] - 1;
                if (m_rem[c] == 0) begin
                    m_tick[c] = 1'b1;
                    m_clk[c]  = ~m_clk[c];
                    if (m_one[c]) m_st[c] = 2;
                    else          m_rem[c] = m_div[c];
                end
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_busy();
        for (int c = 0; c < NCH; c++) exp_busy[c] = (m_st[c] == 1);
    endfunction

    function automatic logic [NCH-1:0] exp_done();
        for (int c = 0; c < NCH; c++) exp_done[c] = (m_st[c] == 2);
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
    endtask

    task automatic do_write(input int ch, input int d, input bit one);
        cfg_we      = 1'b1;
        cfg_ch      = CW'(ch);
        cfg_div     = W'(d);
        cfg_oneshot = one;
        cyc();
        cfg_we      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0; hold = 1'b0;
        s_we = 1'b0; s_ch = '0; s_div = '0; s_oneshot = 1'b0; s_hold = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        n_tests++;
        if ({tick, clk_out, busy, done} !== '0) begin
            n_fail++; $display("FAIL reset_state got=%h exp=0", {tick, clk_out, busy, done});
        end
        do_write(0, 3, 1'b0);
        repeat (4) cyc();
        n_tests++;
        if ({clk_out[0], busy[0]} !== 2'b11) begin
            n_fail++; $display("FAIL pre_reset_run got=%b exp=11", {clk_out[0], busy[0]});
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({tick, clk_out, busy, done} !== '0) begin
            n_fail++; $display("FAIL async_reset got=%h exp=0", {tick, clk_out, busy, done});
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            n_tests++;
            if ({tick, clk_out, busy, done} !== '0) begin
                n_fail++; $display("FAIL post_reset_idle cyc=%0d got=%h exp=0", i, {tick, clk_out, busy, done});
            end
        end
    endtask

    task automatic test_periodic();
        do_write(0, 5, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            cyc();
            n_tests++;
            if ({tick[0], clk_out[0], busy[0]} !== {(i % 5) == 0, ((i / 5) % 2) == 1, 1'b1}) begin
                n_fail++; $display("FAIL periodic_d5 cyc=%0d got=%b exp=%b", i, {tick[0], clk_out[0], busy[0]},
                                   {(i % 5) == 0, ((i / 5) % 2) == 1, 1'b1});
            end
            n_tests++;
            if ({tick, clk_out, busy, done} !== {m_tick, m_clk, exp_busy(), exp_done()}) begin
                n_fail++; $display("FAIL periodic_model cyc=%0d got=%h exp=%h", i, {tick, clk_out, busy, done},
                                   {m_tick, m_clk, exp_busy(), exp_done()});
            end
        end
    endtask

    task automatic test_oneshot();
        do_write(2, 3, 1'b1);
        for (int i = 1; i <= 53; i++) begin
            cyc();
            n_tests++;
            if ({tick[2], busy[2], done[2]} !== {i == 3, i < 3, i >= 3}) begin
                n_fail++; $display("FAIL oneshot_d3 cyc=%0d got=%b exp=%b", i, {tick[2], busy[2], done[2]},
                                   {i == 3, i < 3, i >= 3});
            end
        end
        do_write(2, 0, 1'b0);
        n_tests++;
        if ({tick[2], clk_out[2], busy[2], done[2]} !== 4'b0000) begin
            n_fail++; $display("FAIL oneshot_rewrite_d0 got=%b exp=0000", {tick[2], clk_out[2], busy[2], done[2]});
        end
    endtask

    task automatic test_div1_hold();
        do_write(1, 1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            n_tests++;
            if ({tick[1], clk_out[1]} !== {1'b1, (i % 2) == 1}) begin
                n_fail++; $display("FAIL div1_run cyc=%0d got=%b exp=%b", i, {tick[1], clk_out[1]}, {1'b1, (i % 2) == 1});
            end
        end
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            n_tests++;
            if ({tick, clk_out[1]} !== {{NCH{1'b0}}, 1'b0}) begin
                n_fail++; $display("FAIL hold_freeze cyc=%0d got=%b exp=0", i, {tick, clk_out[1]});
            end
            n_tests++;
            if ({tick, clk_out, busy, done} !== {m_tick, m_clk, exp_busy(), exp_done()}) begin
                n_fail++; $display("FAIL hold_model cyc=%0d got=%h exp=%h", i, {tick, clk_out, busy, done},
                                   {m_tick, m_clk, exp_busy(), exp_done()});
            end
        end
        hold = 1'b0;
        cyc();
        n_tests++;
        if ({tick[1], clk_out[1]} !== 2'b11) begin
            n_fail++; $display("FAIL hold_resume got=%b exp=11", {tick[1], clk_out[1]});
        end
    endtask

    task automatic test_collision();
        do_write(3, 4, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            n_tests++;
            if (tick[3] !== 1'b0) begin
                n_fail++; $display("FAIL collision_pre cyc=%0d got=%b exp=0", i, tick[3]);
            end
        end
        do_write(3, 2, 1'b0);
        for (int i = 0; i <= 2; i++) begin
            if (i > 0) cyc();
            n_tests++;
            if ({tick[3], clk_out[3]} !== {i == 2, i == 2}) begin
                n_fail++; $display("FAIL collision_d2 step=%0d got=%b exp=%b", i, {tick[3], clk_out[3]}, {i == 2, i == 2});
            end
            n_tests++;
            if ({tick, clk_out, busy, done} !== {m_tick, m_clk, exp_busy(), exp_done()}) begin
                n_fail++; $display("FAIL collision_model step=%0d got=%h exp=%h", i, {tick, clk_out, busy, done},
                                   {m_tick, m_clk, exp_busy(), exp_done()});
            end
        end
    endtask

    task automatic test_bad_channel();
        for (int c = 0; c < NCH; c++) do_write(c, 0, 1'b0);
        for (int c = NCH; c < 8; c++) do_write(c, 3, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            n_tests++;
            if ({tick, busy, done} !== '0) begin
                n_fail++; $display("FAIL bad_channel cyc=%0d got=%h exp=0", i, {tick, busy, done});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 1; i <= 400; i++) begin
            cfg_we      = ($urandom % 6) == 0;
            cfg_ch      = CW'($urandom_range(0, 7));
            cfg_div     = W'($urandom_range(0, 9));
            cfg_oneshot = $urandom % 2;
            hold        = ($urandom % 5) == 0;
            cyc();
            n_tests++;
            if ({tick, clk_out, busy, done} !== {m_tick, m_clk, exp_busy(), exp_done()}) begin
                n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, {tick, clk_out, busy, done},
                                   {m_tick, m_clk, exp_busy(), exp_done()});
            end
        end
        cfg_we = 1'b0;
        hold   = 1'b0;
    endtask

    task automatic test_small_max();
        s_we = 1'b1; s_ch = '0; s_div = SW'(15); s_oneshot = 1'b0;
        cyc();
        s_we = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            cyc();
            n_tests++;
            if ({s_tick[0], s_clk_out[0], s_busy[0]} !== {(i % 15) == 0, ((i / 15) % 2) == 1, 1'b1}) begin
                n_fail++; $display("FAIL max_div_w4 cyc=%0d got=%b exp=%b", i, {s_tick[0], s_clk_out[0], s_busy[0]},
                                   {(i % 15) == 0, ((i / 15) % 2) == 1, 1'b1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_div1_hold();
        test_collision();
        test_bad_channel();
        test_random();
        test_small_max();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
